// File: rtl/heart_beat_monitor.sv
// Heartbeat receive-side checker.
// Synchronises an asynchronous square wave and measures each half-period in
// i_clk cycles. Reports every measured interval and keeps sticky too-fast and
// too-slow flags. Declares lock after LOCK_EDGES consecutive in-window
// intervals, and declares loss when no edge arrives for TIMEOUT cycles.
module heart_beat_monitor #(
    parameter int CLK_VALUE   = 100000000,
    parameter int SPEED_GRADE = 2,
    parameter int TOL_SHIFT   = 3,
    parameter int LOCK_EDGES  = 4,
    localparam int HALF       = 2 ** $clog2(CLK_VALUE / SPEED_GRADE),
    localparam int TIMEOUT    = 2 * HALF,
    localparam int PW         = $clog2(TIMEOUT + 1)
) (
    input  logic          i_clk,
    input  logic          i_srst_n,
    input  logic          i_heart_beat,
    input  logic          i_clr_err,
    output logic          o_alive,
    output logic          o_lost,
    output logic          o_err_fast,
    output logic          o_err_slow,
    output logic [PW-1:0] o_period,
    output logic          o_period_valid,
    output logic [15:0]   o_edge_cnt
);

    localparam int TOL = HALF >> TOL_SHIFT;
    localparam int GW  = $clog2(LOCK_EDGES + 1);

    // Window limits and counter limits, all unsigned at PW bits.
    localparam logic [PW-1:0] WIN_LO   = PW'(HALF - TOL);
    localparam logic [PW-1:0] WIN_HI   = PW'(HALF + TOL);
    localparam logic [PW-1:0] CNT_MAX  = PW'(TIMEOUT);
    localparam logic [PW-1:0] CNT_LAST = PW'(TIMEOUT - 1);
    localparam logic [PW-1:0] CNT_ONE  = PW'(1);
    localparam logic [GW-1:0] GOOD_ONE  = GW'(1);
    localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_EDGES);

    typedef enum logic [1:0] {
        S_WAIT_FIRST,
        S_CHECK,
        S_LOCKED
    } state_t;

    // sync_reg[0], sync_reg[1]: synchroniser; sync_reg[2]: delay for edge detect.
    logic [2:0]    sync_reg;
    logic          hb_edge;

    state_t        state_reg,        state_next;
    logic [PW-1:0] cnt_reg,          cnt_next;
    logic [GW-1:0] good_cnt_reg,     good_cnt_next;
    logic          alive_reg,        alive_next;
    logic          lost_reg,         lost_next;
    logic          err_fast_reg,     err_fast_next;
    logic          err_slow_reg,     err_slow_next;
    logic [PW-1:0] period_reg,       period_next;
    logic          period_valid_reg, period_valid_next;
    logic [15:0]   edge_cnt_reg,     edge_cnt_next;

    logic [PW-1:0] interval;
    logic [GW-1:0] good_sum;
    logic          is_fast;
    logic          is_slow;
    logic          timeout_hit;
    logic          set_fast;
    logic          set_slow;

    // Synchroniser and delay flop for the asynchronous heartbeat input.
    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            sync_reg <= 3'b000;
        end else begin
            sync_reg <= {sync_reg[1:0], i_heart_beat};
        end
    end

    // Any transition (rising or falling) of the synchronised input is an edge.
    assign hb_edge     = sync_reg[1] ^ sync_reg[2];
    assign interval    = cnt_reg + CNT_ONE;
    assign good_sum    = good_cnt_reg + GOOD_ONE;
    assign is_fast     = (interval < WIN_LO);
    assign is_slow     = (interval > WIN_HI);
    // An edge in the cycle the counter would hit TIMEOUT takes priority.
    assign timeout_hit = !hb_edge && (cnt_reg == CNT_LAST);

    // Next-state, measurement and flag logic.
    always_comb begin
        state_next        = state_reg;
        cnt_next          = cnt_reg;
        good_cnt_next     = good_cnt_reg;
        alive_next        = alive_reg;
        lost_next         = lost_reg;
        period_next       = period_reg;
        period_valid_next = 1'b0;
        edge_cnt_next     = edge_cnt_reg;
        set_fast          = 1'b0;
        set_slow          = 1'b0;

        if (hb_edge) begin
            cnt_next      = '0;
            edge_cnt_next = edge_cnt_reg + 16'd1;
        end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_ONE;
        end

        if (hb_edge) begin
            case (state_reg)
                S_WAIT_FIRST: begin
                    // First edge only starts the measurement; nothing to report.
                    state_next    = S_CHECK;
                    good_cnt_next = '0;
                    lost_next     = 1'b0;
                end
                S_CHECK, S_LOCKED: begin
                    period_next       = interval;
                    period_valid_next = 1'b1;
                    if (is_fast || is_slow) begin
                        set_fast      = is_fast;
                        set_slow      = is_slow;
                        good_cnt_next = '0;
                        alive_next    = 1'b0;
                        state_next    = S_CHECK;
                    end else if (state_reg == S_CHECK) begin
                        good_cnt_next = good_sum;
                        if (good_sum == GOOD_LOCK) begin
                            state_next = S_LOCKED;
                            alive_next = 1'b1;
                        end
                    end
                end
                default: begin
                    state_next = S_WAIT_FIRST;
                end
            endcase
        end else if (timeout_hit) begin
            lost_next     = 1'b1;
            alive_next    = 1'b0;
            good_cnt_next = '0;
            state_next    = S_WAIT_FIRST;
        end

        // A new error outranks a simultaneous clear request.
        if (set_fast) begin
            err_fast_next = 1'b1;
        end else if (i_clr_err) begin
            err_fast_next = 1'b0;
        end else begin
            err_fast_next = err_fast_reg;
        end

        if (set_slow) begin
            err_slow_next = 1'b1;
        end else if (i_clr_err) begin
            err_slow_next = 1'b0;
        end else begin
            err_slow_next = err_slow_reg;
        end
    end

    // State and output registers; reset discards all history.
    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            state_reg        <= S_WAIT_FIRST;
            cnt_reg          <= '0;
            good_cnt_reg     <= '0;
            alive_reg        <= 1'b0;
            lost_reg         <= 1'b0;
            err_fast_reg     <= 1'b0;
            err_slow_reg     <= 1'b0;
            period_reg       <= '0;
            period_valid_reg <= 1'b0;
            edge_cnt_reg     <= '0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            good_cnt_reg     <= good_cnt_next;
            alive_reg        <= alive_next;
            lost_reg         <= lost_next;
            err_fast_reg     <= err_fast_next;
            err_slow_reg     <= err_slow_next;
            period_reg       <= period_next;
            period_valid_reg <= period_valid_next;
            edge_cnt_reg     <= edge_cnt_next;
        end
    end

    assign o_alive        = alive_reg;
    assign o_lost         = lost_reg;
    assign o_err_fast     = err_fast_reg;
    assign o_err_slow     = err_slow_reg;
    assign o_period       = period_reg;
    assign o_period_valid = period_valid_reg;
    assign o_edge_cnt     = edge_cnt_reg;

endmodule

// File: tb/tb_heart_beat_monitor.sv
// Directed bench for heart_beat_monitor with HALF=32, window [28,36],
// TIMEOUT=64, PW=7.
module tb_heart_beat_monitor;

    logic        clk = 1'b0;
    logic        srst_n;
    logic        hb;
    logic        clr;
    logic        alive;
    logic        lost;
    logic        err_fast;
    logic        err_slow;
    logic [6:0]  period;
    logic        period_valid;
    logic [15:0] edge_cnt;

    heart_beat_monitor #(
        .CLK_VALUE   (64),
        .SPEED_GRADE (2),
        .TOL_SHIFT   (3),
        .LOCK_EDGES  (4)
    ) dut (
        .i_clk          (clk),
        .i_srst_n       (srst_n),
        .i_heart_beat   (hb),
        .i_clr_err      (clr),
        .o_alive        (alive),
        .o_lost         (lost),
        .o_err_fast     (err_fast),
        .o_err_slow     (err_slow),
        .o_period       (period),
        .o_period_valid (period_valid),
        .o_edge_cnt     (edge_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         len;
        logic       clr;
        logic [6:0] period;
        logic       fast;
        logic       slow;
        logic       alive;
    } vec_t;

    typedef struct packed {
        logic [6:0] period;
        logic       fast;
        logic       slow;
        logic       alive;
        logic       lost;
    } ev_t;

    localparam int NV = 21;
    vec_t vecs [NV];
    ev_t  ev_q [$];
    int   total   = 0;
    int   bad     = 0;
    int   tog_cnt = 0;

    // Capture every reported interval together with the flags of that cycle.
    always @(negedge clk) begin
        if (period_valid) begin
            ev_q.push_back({period, err_fast, err_slow, alive, lost});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // Wait n cycles (optionally pulsing clear mid-way), then toggle the input.
    task automatic toggle(input int n, input logic do_clr);
        for (int j = 0; j < n; j++) begin
            clr = (do_clr && j == 10);
            tick();
        end
        clr = 1'b0;
        hb  = ~hb;
        tog_cnt++;
    endtask

    function automatic vec_t mk(input int len, input logic c, input logic [6:0] p,
                                input logic f, input logic s, input logic a);
        vec_t v;
        v.len = len; v.clr = c; v.period = p; v.fast = f; v.slow = s; v.alive = a;
        return v;
    endfunction

    initial begin
        ev_t exp_ev;
        ev_t got_ev;
        int  n;
        int  sz;

        //             len clr per  f  s  a
        vecs[0]  = mk(32, 0, 32, 0, 0, 0);
        vecs[1]  = mk(32, 0, 32, 0, 0, 0);
        vecs[2]  = mk(32, 0, 32, 0, 0, 0);
        vecs[3]  = mk(32, 0, 32, 0, 0, 1);
        vecs[4]  = mk(32, 0, 32, 0, 0, 1);
        vecs[5]  = mk(26, 0, 26, 1, 0, 0);
        vecs[6]  = mk(32, 0, 32, 1, 0, 0);
        vecs[7]  = mk(32, 0, 32, 1, 0, 0);
        vecs[8]  = mk(32, 0, 32, 1, 0, 0);
        vecs[9]  = mk(32, 0, 32, 1, 0, 1);
        vecs[10] = mk(32, 1, 32, 0, 0, 1);
        vecs[11] = mk(36, 0, 36, 0, 0, 1);
        vecs[12] = mk(28, 0, 28, 0, 0, 1);
        vecs[13] = mk(37, 0, 37, 0, 1, 0);
        vecs[14] = mk(27, 0, 27, 1, 1, 0);
        vecs[15] = mk(32, 1, 32, 0, 0, 0);
        vecs[16] = mk(64, 0, 64, 0, 1, 0);
        vecs[17] = mk(32, 1, 32, 0, 0, 0);
        vecs[18] = mk(32, 0, 32, 0, 0, 0);
        vecs[19] = mk(32, 0, 32, 0, 0, 0);
        vecs[20] = mk(32, 0, 32, 0, 0, 1);

        srst_n = 1'b0;
        hb     = 1'b0;
        clr    = 1'b0;
        repeat (4) tick();
        chk("reset_outputs", {alive, lost, err_fast, err_slow, period_valid}, 0);
        chk("reset_period", period, 0);
        chk("reset_edge_cnt", edge_cnt, 0);

        // Table: first edge, then one toggle per row.
        srst_n = 1'b1;
        toggle(10, 1'b0);
        for (int i = 0; i < NV; i++) begin
            toggle(vecs[i].len, vecs[i].clr);
        end
        sz = ev_q.size();
        repeat (5) tick();
        chk("report_count", ev_q.size(), NV);
        chk("edge_count", edge_cnt, tog_cnt);
        for (int i = 0; i < NV && i < ev_q.size(); i++) begin
            exp_ev = {vecs[i].period, vecs[i].fast, vecs[i].slow, vecs[i].alive, 1'b0};
            got_ev = ev_q[i];
            total++;
            if (got_ev !== exp_ev) begin
                bad++;
                $display("FAIL vec%0d: got per=%0d f=%0b s=%0b a=%0b l=%0b expected per=%0d f=%0b s=%0b a=%0b l=0",
                         i, got_ev.period, got_ev.fast, got_ev.slow, got_ev.alive, got_ev.lost,
                         exp_ev.period, exp_ev.fast, exp_ev.slow, exp_ev.alive);
            end else begin
                $display("ok   vec%0d: per=%0d f=%0b s=%0b a=%0b", i,
                         got_ev.period, got_ev.fast, got_ev.slow, got_ev.alive);
            end
        end

        // Timeout after lock: 5 ticks already elapsed since the last toggle.
        n = 5;
        while (!lost && n < 200) begin
            tick();
            n++;
        end
        chk("lost_latency", n, 67);
        chk("lost_alive", alive, 0);

        // Resume: first edge clears lost and reports nothing.
        sz = ev_q.size();
        toggle(0, 1'b0);
        repeat (6) tick();
        chk("resume_lost", lost, 0);
        chk("resume_no_report", ev_q.size(), sz);
        chk("resume_edge_cnt", edge_cnt, tog_cnt);

        // Clear in the same cycle as a new fast error: the error wins.
        toggle(14, 1'b0);
        tick();
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_vs_err_valid", period_valid, 1);
        chk("clr_vs_err_period", period, 20);
        chk("clr_vs_err_fast", err_fast, 1);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_alone", {err_fast, err_slow}, 0);

        // Relock, then reset with the input held high.
        toggle(27, 1'b0);
        for (int i = 0; i < 3; i++) toggle(32, 1'b0);
        repeat (4) tick();
        chk("relock_alive", alive, 1);
        if (!hb) begin
            toggle(28, 1'b0);
            repeat (4) tick();
        end
        srst_n = 1'b0;
        repeat (2) tick();
        chk("midreset_outputs", {alive, lost, err_fast, err_slow, period_valid}, 0);
        chk("midreset_period", period, 0);
        chk("midreset_edge_cnt", edge_cnt, 0);
        ev_q.delete();
        srst_n  = 1'b1;
        tog_cnt = 1;
        repeat (10) tick();
        chk("spurious_no_report", ev_q.size(), 0);
        chk("spurious_edge_cnt", edge_cnt, 1);
        chk("spurious_no_err", {err_fast, err_slow, lost}, 0);
        toggle(20, 1'b0);
        repeat (5) tick();
        chk("post_reset_reports", ev_q.size(), 1);
        if (ev_q.size() > 0) begin
            got_ev = ev_q[0];
            chk("post_reset_event", got_ev, {7'd30, 1'b0, 1'b0, 1'b0, 1'b0});
        end
        chk("post_reset_edge_cnt", edge_cnt, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
